// File: rtl/softmax_pkg.sv
// Shared softmax datapath definitions: IEEE-754 single field layout and
// fixed-point defaults used between get_exp and the normalising divider.
package softmax_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam int IW_DEF   = 8;
  localparam int FW_DEF   = 24;
  localparam int FXW_DEF  = IW_DEF + FW_DEF;

  typedef logic [FXW_DEF-1:0] ufix_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/fp32_to_ufix.sv
// Combinational float32 -> unsigned UQ IW.FW conversion with truncation,
// saturation on large/inf/NaN inputs and a flag for negative nonzero inputs.
module fp32_to_ufix
  import softmax_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic [31:0]      in_data,
  output logic [IW+FW-1:0] value,
  output logic             neg,
  output logic             sat
);

  localparam int FXW = IW + FW;
  localparam logic signed [9:0] SHIFT_BIAS = 10'(EXP_BIAS + MANT_W - FW);
  localparam logic [8:0]        SAT_EXP    = 9'(EXP_BIAS + IW);

  fp32_t                  f;
  logic [FXW-1:0]         mant_ext;
  logic signed [9:0]      shift;
  logic [9:0]             rsh;

  assign f        = in_data;
  assign mant_ext = {{(FXW-MANT_W-1){1'b0}}, 1'b1, f.mant};
  assign shift    = $signed({2'b00, f.expo}) - SHIFT_BIAS;
  assign rsh      = -shift;

  // NOTE: every output gets a default first so no path through the if-chain
  // leaves one unassigned; that is what keeps this block free of latches.
  always_comb begin
    value = '0;
    neg   = 1'b0;
    sat   = 1'b0;
    if (f.expo == '0) begin
      value = '0;
    end else if (f.sign) begin
      neg = 1'b1;
    end else if (f.expo == '1 || {1'b0, f.expo} >= SAT_EXP) begin
      sat   = 1'b1;
      value = '1;
    end else if (!shift[9]) begin
      value = mant_ext << shift;
    end else if (rsh < 10'd24) begin
      value = mant_ext >> rsh;
    end
  end

endmodule

// File: rtl/exp_sum_buffer.sv
// Buffers one vector of converted exp values while summing them, then replays
// each element alongside the complete sum so the divider sees the denominator first.
module exp_sum_buffer
  import softmax_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = IW_DEF,
  parameter int FW    = FW_DEF,
  localparam int FXW  = IW + FW,
  localparam int AW   = $clog2(DEPTH),
  localparam int SW   = FXW + AW,
  localparam int CW   = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [FXW-1:0] out_data,
  output logic [SW-1:0]  out_sum,
  output logic           out_last,
  output logic [CW-1:0]  out_count,
  output logic           err_neg,
  output logic           err_ovf
);

  localparam logic FILL  = 1'b0;
  localparam logic DRAIN = 1'b1;

  logic           state;
  logic [AW-1:0]  wr_cnt;
  logic [AW-1:0]  rd_ptr;
  logic [SW-1:0]  sum_q;
  logic [FXW-1:0] mem [DEPTH];

  logic [FXW-1:0] cvt_value;
  logic [FXW-1:0] fix_val;
  logic           cvt_neg;
  logic           cvt_sat;
  logic           in_fire;
  logic           out_fire;
  logic           wr_full;
  logic           vec_last;

  fp32_to_ufix #(.IW(IW), .FW(FW)) u_cvt (
    .in_data (in_data),
    .value   (cvt_value),
    .neg     (cvt_neg),
    .sat     (cvt_sat)
  );

  assign fix_val   = cvt_sat ? {FXW{1'b1}} : cvt_value;
  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_full   = (wr_cnt == AW'(DEPTH - 1));
  assign vec_last  = in_last || wr_full;

  // Outputs are addressed by rd_ptr, so they stay put while the consumer stalls.
  assign out_data  = mem[rd_ptr];
  assign out_sum   = sum_q;
  assign out_last  = out_valid && (CW'(rd_ptr) == out_count - CW'(1));

  // NOTE: the element buffer has no reset; wr_cnt/out_count gate every read,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_cnt] <= fix_val;
  end

  // NOTE: all state updates use non-blocking assignments so each register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      sum_q     <= '0;
      out_count <= '0;
      err_neg   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (in_fire && cvt_neg) err_neg <= 1'b1;
      case (state)
        FILL: begin
          if (in_fire) begin
            sum_q  <= sum_q + SW'(fix_val);
            wr_cnt <= wr_cnt + AW'(1);
            if (vec_last) begin
              state     <= DRAIN;
              out_count <= CW'(wr_cnt) + CW'(1);
              rd_ptr    <= '0;
              if (wr_full && !in_last) err_ovf <= 1'b1;
            end
          end
        end
        default: begin
          if (out_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
            if (out_last) begin
              state  <= FILL;
              wr_cnt <= '0;
              sum_q  <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_sum_buffer.sv
// Directed scoreboard bench for exp_sum_buffer with DEPTH=4: expected elements
// are queued as inputs are accepted and popped as the replay is consumed.
module tb_exp_sum_buffer;

  localparam int DEPTH = 4;
  localparam int FXW   = 32;
  localparam int SW    = FXW + $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [FXW-1:0] out_data;
  logic [SW-1:0]  out_sum;
  logic           out_last;
  logic [CW-1:0]  out_count;
  logic           err_neg;
  logic           err_ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0]   q [$];
  logic [SW-1:0] exp_sum;
  int            exp_cnt;

  exp_sum_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_count (out_count),
    .err_neg   (err_neg),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one element; expected fixed value enters the scoreboard on acceptance.
  task automatic send(input logic [31:0] d, input logic last, input logic [31:0] exp_fx);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_timeout", 64'(in_ready), 64'(1));
    q.push_back(exp_fx);
    exp_sum = exp_sum + SW'(exp_fx);
    exp_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Consume the replay; rdy_pat[k] drives out_ready on cycle k, then 1.
  task automatic drain(input logic [7:0] rdy_pat, input int pat_len);
    int          cyc = 0;
    logic [31:0] held = '0;
    logic        held_v = 1'b0;
    logic [31:0] e;
    while (q.size() > 0 && cyc < 50) begin
      out_ready = (cyc < pat_len) ? rdy_pat[cyc] : 1'b1;
      if (out_valid) begin
        check("drain_in_ready", 64'(in_ready), 64'(0));
        if (held_v) check("stall_hold", 64'(out_data), 64'(held));
        if (out_ready) begin
          e = q.pop_front();
          check("out_data", 64'(out_data), 64'(e));
          check("out_sum", 64'(out_sum), 64'(exp_sum));
          check("out_last", 64'(out_last), 64'(q.size() == 0));
          check("out_count", 64'(out_count), 64'(exp_cnt));
          held_v = 1'b0;
        end else begin
          held   = out_data;
          held_v = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_timeout", 64'(q.size()), 64'(0));
    check("post_drain_in_ready", 64'(in_ready), 64'(1));
    check("post_drain_out_valid", 64'(out_valid), 64'(0));
    exp_sum = '0;
    exp_cnt = 0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    exp_sum   = '0;
    exp_cnt   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out_count", 64'(out_count), 64'(0));
    check("rst_err_neg", 64'(err_neg), 64'(0));
    check("rst_err_ovf", 64'(err_ovf), 64'(0));

    // 1.0, 2.0, 0.5 -> sum 3.5
    send(32'h3F800000, 1'b0, 32'h01000000);
    check("fill_out_valid", 64'(out_valid), 64'(0));
    send(32'h40000000, 1'b0, 32'h02000000);
    send(32'h3F000000, 1'b1, 32'h00800000);
    check("latency_out_valid", 64'(out_valid), 64'(1));
    check("latency_in_ready", 64'(in_ready), 64'(0));
    check("v1_sum_value", 64'(exp_sum), 64'h03800000);
    drain(8'hFF, 0);

    // Saturation and zero
    send(32'h43960000, 1'b0, 32'hFFFFFFFF);
    send(32'h00000000, 1'b1, 32'h00000000);
    drain(8'hFF, 0);
    check("sat_err_neg", 64'(err_neg), 64'(0));
    check("sat_err_ovf", 64'(err_ovf), 64'(0));

    // Negative input, then smallest representable positive
    send(32'hBF800000, 1'b1, 32'h00000000);
    check("neg_err_neg", 64'(err_neg), 64'(1));
    drain(8'hFF, 0);
    send(32'h33800000, 1'b1, 32'h00000001);
    drain(8'hFF, 0);
    check("neg_sticky", 64'(err_neg), 64'(1));

    // Overflow: DEPTH elements without in_last, drained with stalls 1,0,0,1,1
    for (int i = 0; i < DEPTH; i++) send(32'h3F800000, 1'b0, 32'h01000000);
    check("ovf_out_valid", 64'(out_valid), 64'(1));
    check("ovf_err_ovf", 64'(err_ovf), 64'(1));
    check("ovf_sum_value", 64'(exp_sum), 64'h04000000);
    drain(8'b0001_1001, 5);
    check("ovf_sticky", 64'(err_ovf), 64'(1));

    // Reset in the middle of a drain
    send(32'h3F800000, 1'b0, 32'h01000000);
    send(32'h40000000, 1'b1, 32'h02000000);
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_sum = '0;
    exp_cnt = 0;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_err_neg", 64'(err_neg), 64'(0));
    check("mid_rst_err_ovf", 64'(err_ovf), 64'(0));
    send(32'h3F800000, 1'b1, 32'h01000000);
    drain(8'hFF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
